// File: rtl/sha_mem_responder.sv
// -----------------------------------------------------------------------------
// sha_mem_responder
//
// Word-addressed RAM that serves the SHA-256 core's memory-master bus with a
// one-cycle read latency. It also exposes a host port for preloading the
// message and reading back the digest while the core is idle. Core writes
// into the 8-word digest window starting at output_addr are tracked so the
// controller can tell when the whole 256-bit digest has landed.
//
// Ports
//   clk, reset_n     single clock, asynchronous active-low reset
//   core_en          1: core owns the memory, host stalls
//   mem_addr/mem_we/mem_write_data/mem_read_data
//                    core bus; read data is for the address of the previous edge
//   output_addr      base word address of the digest window
//   win_clear        clears digest tracking (wins over a coincident write)
//   host_req/host_we/host_addr/host_wdata
//                    host request, accepted on any edge with core_en=0
//   host_rdata       read data, valid with host_ack, held between reads
//   host_ack         pulse one cycle after each acceptance
//   digest_valid     all 8 window words written since the last clear
//   wr_count         number of distinct window words written (0..8)
//   addr_err         sticky flag for any access at or above DEPTH
// -----------------------------------------------------------------------------
module sha_mem_responder #(
  parameter int DEPTH = 256,
  parameter int AW    = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          core_en,
  input  logic [AW-1:0] mem_addr,
  input  logic          mem_we,
  input  logic [31:0]   mem_write_data,
  output logic [31:0]   mem_read_data,
  input  logic [AW-1:0] output_addr,
  input  logic          win_clear,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [31:0]   host_wdata,
  output logic [31:0]   host_rdata,
  output logic          host_ack,
  output logic          digest_valid,
  output logic [3:0]    wr_count,
  output logic          addr_err
);

  localparam int DATA_W = 32;
  localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // True when the word address falls inside the physical RAM.
  function automatic logic addr_in_range(input logic [AW-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] m);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, m[i]};
    return c;
  endfunction

  // Storage is deliberately not reset so contents survive a reset pulse.
  logic [DATA_W-1:0] ram_q [DEPTH];

  logic [DATA_W-1:0] mem_read_data_q, mem_read_data_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
  logic              host_ack_q, host_ack_d;
  logic [7:0]        mask_q, mask_d;
  logic [3:0]        wr_count_q, wr_count_d;
  logic              digest_valid_q, digest_valid_d;
  logic              addr_err_q, addr_err_d;

  // Active-port signals after owner selection.
  logic              host_acc;
  logic              act;
  logic [AW-1:0]     a_addr;
  logic              a_we;
  logic [DATA_W-1:0] a_wdata;
  logic              in_range;
  logic [IW-1:0]     a_idx;
  logic              wr_en;
  logic [DATA_W-1:0] rd_word;

  logic [AW-1:0]     win_off;
  logic              win_hit;

  // Owner select: the core always wins; a host request is accepted only on
  // an edge where the core does not own the memory. Core mem_we is ignored
  // when the core is not the owner.
  always_comb begin
    host_acc = !core_en && host_req;
    act      = core_en || host_acc;
    a_addr   = core_en ? mem_addr : host_addr;
    a_we     = core_en ? mem_we : (host_acc && host_we);
    a_wdata  = core_en ? mem_write_data : host_wdata;
  end

  always_comb begin
    in_range = addr_in_range(a_addr);
    a_idx    = IW'(a_addr);
    wr_en    = act && a_we && in_range;
    // Write-first: a write cycle returns the data being written. Out-of-range
    // accesses read as zero.
    if (!in_range)  rd_word = '0;
    else if (a_we)  rd_word = a_wdata;
    else            rd_word = ram_q[a_idx];
  end

  // Digest window: the offset is a wrapping AW-bit difference, so a window
  // based near the top of the address space continues at address 0. The mask
  // bit is set even if the word itself lies outside the RAM.
  always_comb begin
    win_off = mem_addr - output_addr;
    win_hit = core_en && mem_we && (win_off < AW'(8));
    mask_d  = mask_q;
    if (win_clear)    mask_d = '0;
    else if (win_hit) mask_d = mask_q | (8'b0000_0001 << win_off[2:0]);
  end

  always_comb begin
    mem_read_data_d = mem_read_data_q;
    if (core_en) mem_read_data_d = rd_word;

    host_rdata_d = host_rdata_q;
    if (host_acc && !host_we) host_rdata_d = rd_word;

    host_ack_d     = host_acc;
    wr_count_d     = popcount8(mask_d);
    digest_valid_d = &mask_d;

    addr_err_d = addr_err_q;
    if (act && !in_range) addr_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) ram_q[a_idx] <= a_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_read_data_q <= '0;
      host_rdata_q    <= '0;
      host_ack_q      <= 1'b0;
      mask_q          <= '0;
      wr_count_q      <= '0;
      digest_valid_q  <= 1'b0;
      addr_err_q      <= 1'b0;
    end else begin
      mem_read_data_q <= mem_read_data_d;
      host_rdata_q    <= host_rdata_d;
      host_ack_q      <= host_ack_d;
      mask_q          <= mask_d;
      wr_count_q      <= wr_count_d;
      digest_valid_q  <= digest_valid_d;
      addr_err_q      <= addr_err_d;
    end
  end

  assign mem_read_data = mem_read_data_q;
  assign host_rdata    = host_rdata_q;
  assign host_ack      = host_ack_q;
  assign digest_valid  = digest_valid_q;
  assign wr_count      = wr_count_q;
  assign addr_err      = addr_err_q;

endmodule

// File: tb/tb_sha_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_sha_mem_responder
//
// Directed bench for sha_mem_responder: table of {inputs, expected outputs}
// records applied one per clock, plus hand-written sequences for host
// preload and for reset behaviour.
// -----------------------------------------------------------------------------
module tb_sha_mem_responder;

  localparam logic [5:0] C_MRD = 6'h01;
  localparam logic [5:0] C_HRD = 6'h02;
  localparam logic [5:0] C_ACK = 6'h04;
  localparam logic [5:0] C_DV  = 6'h08;
  localparam logic [5:0] C_CNT = 6'h10;
  localparam logic [5:0] C_ERR = 6'h20;

  typedef struct {
    string       name;
    logic        ce;
    logic        we;
    logic [15:0] ma;
    logic [31:0] wd;
    logic        hr;
    logic        hw;
    logic [15:0] ha;
    logic [31:0] hd;
    logic [15:0] oa;
    logic        wc;
    logic [5:0]  chk;
    logic [31:0] e_mrd;
    logic [31:0] e_hrd;
    logic        e_ack;
    logic        e_dv;
    logic [3:0]  e_cnt;
    logic        e_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        core_en = 1'b0;
  logic [15:0] mem_addr = '0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_write_data = '0;
  logic [31:0] mem_read_data;
  logic [15:0] output_addr = 16'd100;
  logic        win_clear = 1'b0;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [15:0] host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic [31:0] host_rdata;
  logic        host_ack;
  logic        digest_valid;
  logic [3:0]  wr_count;
  logic        addr_err;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[$];

  sha_mem_responder #(.DEPTH(256), .AW(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .core_en        (core_en),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .output_addr    (output_addr),
    .win_clear      (win_clear),
    .host_req       (host_req),
    .host_we        (host_we),
    .host_addr      (host_addr),
    .host_wdata     (host_wdata),
    .host_rdata     (host_rdata),
    .host_ack       (host_ack),
    .digest_valid   (digest_valid),
    .wr_count       (wr_count),
    .addr_err       (addr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string nm, input logic ce, input logic we,
                              input logic [15:0] ma, input logic [31:0] wd,
                              input logic hr, input logic hw,
                              input logic [15:0] ha, input logic [31:0] hd,
                              input logic [15:0] oa, input logic wc,
                              input logic [5:0] chk,
                              input logic [31:0] e_mrd, input logic [31:0] e_hrd,
                              input logic e_ack, input logic e_dv,
                              input logic [3:0] e_cnt, input logic e_err);
    vec_t t;
    t.name = nm;  t.ce = ce;  t.we = we;  t.ma = ma;  t.wd = wd;
    t.hr = hr;    t.hw = hw;  t.ha = ha;  t.hd = hd;  t.oa = oa;  t.wc = wc;
    t.chk = chk;  t.e_mrd = e_mrd;  t.e_hrd = e_hrd;  t.e_ack = e_ack;
    t.e_dv = e_dv;  t.e_cnt = e_cnt;  t.e_err = e_err;
    return t;
  endfunction

  task automatic check_all_zero(input string nm);
    check({nm, "/mrd"}, mem_read_data, 32'h0);
    check({nm, "/hrd"}, host_rdata, 32'h0);
    check({nm, "/ack"}, {31'b0, host_ack}, 32'h0);
    check({nm, "/dv"},  {31'b0, digest_valid}, 32'h0);
    check({nm, "/cnt"}, {28'b0, wr_count}, 32'h0);
    check({nm, "/err"}, {31'b0, addr_err}, 32'h0);
  endtask

  task automatic host_cycle(input logic we, input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    core_en = 1'b0;  mem_we = 1'b0;  win_clear = 1'b0;
    host_req = 1'b1; host_we = we;   host_addr = a;  host_wdata = d;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t t);
    @(negedge clk);
    core_en = t.ce;  mem_we = t.we;  mem_addr = t.ma;  mem_write_data = t.wd;
    host_req = t.hr; host_we = t.hw; host_addr = t.ha; host_wdata = t.hd;
    output_addr = t.oa;  win_clear = t.wc;
    @(posedge clk);
    #1;
    if (t.chk[0]) check({t.name, "/mrd"}, mem_read_data, t.e_mrd);
    if (t.chk[1]) check({t.name, "/hrd"}, host_rdata, t.e_hrd);
    if (t.chk[2]) check({t.name, "/ack"}, {31'b0, host_ack}, {31'b0, t.e_ack});
    if (t.chk[3]) check({t.name, "/dv"},  {31'b0, digest_valid}, {31'b0, t.e_dv});
    if (t.chk[4]) check({t.name, "/cnt"}, {28'b0, wr_count}, {28'b0, t.e_cnt});
    if (t.chk[5]) check({t.name, "/err"}, {31'b0, addr_err}, {31'b0, t.e_err});
  endtask

  initial begin : main
    logic [15:0] dig_addr [9];
    logic [3:0]  dig_cnt  [9];
    logic [15:0] wrap_addr [8];

    dig_addr = '{16'd105, 16'd100, 16'd103, 16'd107, 16'd103, 16'd101, 16'd106, 16'd102, 16'd104};
    dig_cnt  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    wrap_addr = '{16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0002, 16'h0003};

    // ---- vector table ----
    for (int i = 0; i < 20; i++)
      vecs.push_back(mk("core_rd", 1, 0, 16'(i), 0, 0, 0, 0, 0, 16'd100, 0,
                        C_MRD | C_ACK | C_ERR, 32'h1000 + i, 0, 0, 0, 0, 0));
    vecs.push_back(mk("mrd_hold", 0, 0, 16'd5, 0, 0, 0, 0, 0, 16'd100, 0,
                      C_MRD | C_ACK, 32'h1013, 0, 0, 0, 0, 0));
    vecs.push_back(mk("rdw", 1, 1, 16'd7, 32'hDEADBEEF, 0, 0, 0, 0, 16'd100, 0,
                      C_MRD | C_CNT, 32'hDEADBEEF, 0, 0, 0, 0, 0));
    vecs.push_back(mk("host_rd7", 0, 0, 0, 0, 1, 0, 16'd7, 0, 16'd100, 0,
                      C_MRD | C_HRD | C_ACK, 32'hDEADBEEF, 32'hDEADBEEF, 1, 0, 0, 0));
    for (int i = 0; i < 9; i++)
      vecs.push_back(mk("digest", 1, 1, dig_addr[i], 32'hA000 + 32'(dig_addr[i]), 0, 0, 0, 0,
                        16'd100, 0, C_MRD | C_CNT | C_DV | C_ACK,
                        32'hA000 + 32'(dig_addr[i]), 0, 0, (i == 8), dig_cnt[i], 0));
    vecs.push_back(mk("host_wr_win", 0, 0, 0, 0, 1, 1, 16'd100, 32'h0, 16'd100, 0,
                      C_CNT | C_DV | C_ACK, 0, 0, 1, 1, 4'd8, 0));
    vecs.push_back(mk("clear", 0, 0, 0, 0, 0, 0, 0, 0, 16'd100, 1,
                      C_CNT | C_DV | C_ACK, 0, 0, 0, 0, 4'd0, 0));
    vecs.push_back(mk("clear_wins", 1, 1, 16'd100, 32'hB100, 0, 0, 0, 0, 16'd100, 1,
                      C_MRD | C_CNT | C_DV, 32'hB100, 0, 0, 0, 4'd0, 0));
    vecs.push_back(mk("clear_ram", 1, 0, 16'd100, 0, 0, 0, 0, 0, 16'd100, 0,
                      C_MRD | C_CNT, 32'hB100, 0, 0, 0, 4'd0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk("arb_stall", 1, 0, 16'd10, 0, 1, 1, 16'd10, 32'hCAFE0010, 16'd100, 0,
                        C_MRD | C_ACK, 32'h100A, 0, 0, 0, 0, 0));
    vecs.push_back(mk("arb_accept", 0, 0, 16'd10, 0, 1, 1, 16'd10, 32'hCAFE0010, 16'd100, 0,
                      C_MRD | C_ACK, 32'h100A, 0, 1, 0, 0, 0));
    vecs.push_back(mk("arb_rdback", 0, 0, 0, 0, 1, 0, 16'd10, 0, 16'd100, 0,
                      C_HRD | C_ACK, 0, 32'hCAFE0010, 1, 0, 0, 0));
    vecs.push_back(mk("idle_hold", 0, 0, 0, 0, 0, 0, 0, 0, 16'd100, 0,
                      C_HRD | C_ACK, 0, 32'hCAFE0010, 0, 0, 0, 0));
    vecs.push_back(mk("wr_255", 0, 0, 0, 0, 1, 1, 16'd255, 32'hFF00FF00, 16'd100, 0,
                      C_ACK | C_ERR, 0, 0, 1, 0, 0, 0));
    vecs.push_back(mk("rd_255", 0, 0, 0, 0, 1, 0, 16'd255, 0, 16'd100, 0,
                      C_HRD | C_ACK | C_ERR, 0, 32'hFF00FF00, 1, 0, 0, 0));
    vecs.push_back(mk("wr_256", 0, 0, 0, 0, 1, 1, 16'd256, 32'h12345678, 16'd100, 0,
                      C_ACK | C_ERR, 0, 0, 1, 0, 0, 1));
    vecs.push_back(mk("rd_300", 0, 0, 0, 0, 1, 0, 16'd300, 0, 16'd100, 0,
                      C_HRD | C_ACK | C_ERR, 0, 32'h0, 1, 0, 0, 1));
    vecs.push_back(mk("rd_0_noalias", 0, 0, 0, 0, 1, 0, 16'd0, 0, 16'd100, 0,
                      C_HRD | C_ERR, 0, 32'h1000, 1, 0, 0, 1));
    vecs.push_back(mk("clear_wrap", 0, 0, 0, 0, 0, 0, 0, 0, 16'hFFFC, 1,
                      C_CNT | C_DV, 0, 0, 0, 0, 4'd0, 0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk("wrap", 1, 1, wrap_addr[i], 32'hC000 + i, 0, 0, 0, 0, 16'hFFFC, 0,
                        C_MRD | C_CNT | C_DV | C_ERR,
                        (i < 4) ? 32'h0 : 32'hC000 + i, 0, 0, (i == 7), 4'(i + 1), 1));
    vecs.push_back(mk("wrap_rd0", 1, 0, 16'd0, 0, 0, 0, 0, 0, 16'hFFFC, 0,
                      C_MRD | C_CNT | C_DV, 32'hC004, 0, 0, 1, 4'd8, 0));

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;

    // ---- host preload with back-to-back acks ----
    for (int i = 0; i < 20; i++) begin
      host_cycle(1'b1, 16'(i), 32'h1000 + i);
      check("preload_ack", {31'b0, host_ack}, 32'h1);
    end
    host_cycle(1'b0, 16'd5, 32'h0);
    check("preload_rd5_ack", {31'b0, host_ack}, 32'h1);
    check("preload_rd5", host_rdata, 32'h1005);
    check("preload_err", {31'b0, addr_err}, 32'h0);

    // ---- table ----
    foreach (vecs[k]) apply(vecs[k]);

    // ---- reset during an in-flight host read ----
    @(negedge clk);
    core_en = 1'b0;  mem_we = 1'b0;  win_clear = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'd5;
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(posedge clk);
    #1 check_all_zero("in_reset");
    @(negedge clk);
    reset_n = 1'b1;
    host_req = 1'b0;
    @(posedge clk);
    #1 check("lost_ack", {31'b0, host_ack}, 32'h0);
    check("post_reset_err", {31'b0, addr_err}, 32'h0);
    check("post_reset_cnt", {28'b0, wr_count}, 32'h0);
    host_cycle(1'b0, 16'd5, 32'h0);
    check("retained_ack", {31'b0, host_ack}, 32'h1);
    check("retained_rd5", host_rdata, 32'h1005);
    @(negedge clk);
    host_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sha_mem_responder.md
Name: sha_mem_responder

Overview:
- Word-addressed memory responder serving the SHA-256 core's memory-master bus (mem_addr / mem_we / mem_write_data / mem_read_data), with 1-cycle read latency.
- Adds a host-side load/readback port, so a testbench or controller can preload the message and read back the digest while the core is not active.
- Tracks core writes into the 8-word digest window at output_addr and flags when the full 256-bit digest has landed.

Parameters:
- DEPTH, 256, number of 32-bit words; legal addresses are 0..DEPTH-1.
- AW, 16, address width (matches core mem_addr).

Ports:
- clk  in  1  single clock; core mem_clk is this same clock.
- reset_n  in  1  asynchronous active-low reset.
- core_en  in  1  core owns the memory (driven high by controller while core is busy).
- mem_addr  in  16  core word address.
- mem_we  in  1  core write enable.
- mem_write_data  in  32  core write data.
- mem_read_data  out  32  read data for the address sampled on the previous edge.
- output_addr  in  16  base of the 8-word digest window.
- win_clear  in  1  clears digest tracking.
- host_req  in  1  host access request (level, held until accepted).
- host_we  in  1  host write.
- host_addr  in  16  host word address.
- host_wdata  in  32  host write data.
- host_rdata  out  32  host read data, valid with host_ack.
- host_ack  out  1  one-cycle pulse, one cycle after acceptance.
- digest_valid  out  1  all 8 digest words written since last clear.
- wr_count  out  4  number of distinct digest words written (0..8).
- addr_err  out  1  sticky: an out-of-range access occurred.

Behaviour:
- Reset (async, reset_n=0): mem_read_data=0, host_rdata=0, host_ack=0, digest_valid=0, wr_count=0, addr_err=0, digest mask=0. RAM contents are not reset and are retained across reset.
- Reset released mid-access: the access is lost. No ack is issued for a request that was in flight during reset.
- Owner select (combinational each cycle):
  - core_en=1: the core port is active; host requests stall, host_ack=0.
  - core_en=0: the host port is active if host_req=1; core mem_we is ignored.
- Core port, every cycle core_en=1:
  - If mem_we=1, write RAM[mem_addr].
  - mem_read_data <= RAM[mem_addr] at the same edge, write-first: a write cycle returns the newly written data next cycle.
  - When core_en=0, mem_read_data holds its last value.
- Host port: acceptance happens on an edge where core_en=0 and host_req=1.
  - Accepted write: RAM[host_addr] <= host_wdata.
  - Accepted read: host_rdata <= RAM[host_addr] (write-first).
  - host_ack=1 on the cycle after acceptance for both reads and writes.
  - Back-to-back: host_req held high gives one acceptance per cycle, so host_ack stays high continuously, pipelined.
  - host_rdata holds between acks.
- Range check: an address >= DEPTH on the active port has these effects:
  - write dropped;
  - read returns 32'h0;
  - addr_err <= 1 (sticky until reset);
  - host_ack still issued.
- Digest tracking, core writes only:
  - If mem_we=1, core_en=1 and (mem_addr - output_addr) is in 0..7, computed as a 16-bit unsigned difference with wrap, set mask bit [offset].
  - wr_count = popcount(mask). digest_valid = (mask==8'hFF), registered.
  - A rewrite of an already-set offset does not change the count.
  - Host writes never affect the mask.
- win_clear=1: mask <= 0 and digest_valid <= 0. If a core write to the window coincides with win_clear, clear wins and that write is not counted; the RAM write still occurs.
- output_addr is sampled per cycle; changing it mid-computation is a controller error, and the behaviour is the simple per-cycle comparison above.
- Window wrap: output_addr=16'hFFFC covers addresses FFFC..FFFF and 0000..0003. Addresses at or above DEPTH are still dropped, but their mask bit is still set.

Test Plan:
1. Host preload, with core_en=0: write RAM[0..19] = 32'h1000+i, then read RAM[5] -> host_ack one cycle after the request, host_rdata=32'h1005. With host_req held for 20 cycles, 20 consecutive acks.
2. Core read latency, with core_en=1: mem_addr=3 at edge n -> mem_read_data=32'h1003 after edge n. Sweep addresses 0..19 back-to-back -> each word appears exactly one cycle late.
3. Read-during-write: mem_addr=7, mem_we=1, mem_write_data=32'hDEADBEEF -> next-cycle mem_read_data=32'hDEADBEEF; host readback of RAM[7]=32'hDEADBEEF.
4. Digest window:
   - output_addr=100, core writes 100..107 in scrambled order with 103 written twice -> wr_count steps 1..8, digest_valid=1 only after the 8th distinct offset.
   - win_clear -> wr_count=0, digest_valid=0.
5. Arbitration: host_req=1 while core_en=1 for 5 cycles -> no host_ack, RAM untouched by the host. When core_en drops, ack arrives one cycle later and the write is applied.
6. Errors and reset:
   - host write to address DEPTH (256) -> write dropped, host_ack issued, addr_err=1.
   - Later host read of 300 -> host_rdata=0, addr_err stays 1.
   - reset_n pulse -> addr_err=0, all outputs 0, RAM[5] still 32'h1005.
